// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage.
// Data requests have fixed priority; stalled transactions abort after MAX_WAIT cycles.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  wait_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              timeout_q;

  logic busy;
  logic expire;
  logic done;

  // The abort fires in the cycle whose increment would bring the count to MAX_WAIT,
  // which lands it exactly MAX_WAIT cycles after the request was sampled.
  assign busy   = (state_q != IDLE);
  assign expire = busy && !mem_ready && (wait_q == CNT_W'(MAX_WAIT - 1));
  assign done   = busy && (mem_ready || expire);

  assign i_ack   = (state_q == BUSY_I) && done;
  assign d_ack   = (state_q == BUSY_D) && done;
  assign i_rdata = ((state_q == BUSY_I) && mem_ready) ? mem_rdata : '0;
  assign d_rdata = ((state_q == BUSY_D) && mem_ready) ? mem_rdata : '0;

  assign stall_if  = i_req & ~i_ack;
  assign stall_mem = d_req & ~d_ack;

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign timeout_err = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wait_q <= '0;
          if (d_req) begin
            state_q     <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
          end else if (i_req) begin
            state_q    <= BUSY_I;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= i_addr;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            wait_q    <= '0;
            if (expire) begin
              timeout_q <= 1'b1;
            end
          end else if (wait_q < CNT_W'(MAX_WAIT)) begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          wait_q    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// hand sequences for collision, back-to-back loads and reset mid-transaction.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_we;
  logic          i_ack, d_ack, stall_if, stall_mem;
  logic          mem_req, mem_we, mem_ready, timeout_err;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata, rdata_drv;
  logic          use_model;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Simple memory model for back-to-back loads: data is a function of address.
  assign mem_rdata = use_model ? {~mem_addr[15:0], mem_addr[15:0]} : rdata_drv;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    int          exp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_terr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          cyc;
    logic        got;
    logic        ack, other;
    logic [31:0] rd;
    mem_ready = 1'b0;
    rdata_drv = v.rdata;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    #1;
    chk($sformatf("v%0d stall_c0", idx), v.is_d ? stall_mem : stall_if, 1);
    chk($sformatf("v%0d mem_req_c0", idx), mem_req, 0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      mem_ready = (cyc > v.waits);
      #1;
      ack   = v.is_d ? d_ack : i_ack;
      other = v.is_d ? i_ack : d_ack;
      rd    = v.is_d ? d_rdata : i_rdata;
      chk($sformatf("v%0d mem_req_c%0d", idx, cyc), mem_req, 1);
      chk($sformatf("v%0d mem_addr_c%0d", idx, cyc), mem_addr, v.addr);
      chk($sformatf("v%0d mem_we_c%0d", idx, cyc), mem_we, v.is_d & v.we);
      if (v.is_d && v.we)
        chk($sformatf("v%0d mem_wdata_c%0d", idx, cyc), mem_wdata, v.wdata);
      chk($sformatf("v%0d other_ack_c%0d", idx, cyc), other, 0);
      if (ack) begin
        got = 1'b1;
        chk($sformatf("v%0d ack_cycle", idx), cyc, v.exp_cyc);
        if (!(v.is_d && v.we))
          chk($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
        chk($sformatf("v%0d stall_at_ack", idx), v.is_d ? stall_mem : stall_if, 0);
        if (v.is_d) d_req = 1'b0;
        else        i_req = 1'b0;
      end
    end
    if (!got) begin
      chk($sformatf("v%0d ack_seen", idx), 0, 1);
      d_req = 1'b0;
      i_req = 1'b0;
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    #1;
    chk($sformatf("v%0d mem_req_after", idx), mem_req, 0);
    chk($sformatf("v%0d timeout_err", idx), timeout_err, v.exp_terr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addrs[4];
    logic [31:0] a;
    int          k;
    vec_t        fv;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 0,  32'h2008_0005, 1,  32'h2008_0005, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 3,  32'h1234_5678, 4,  32'h1234_5678, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 0, 32'h0, 1, 32'h0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0, 14, 32'h0BAD_F00D, 15, 32'h0BAD_F00D, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0, 99, 32'hFFFF_FFFF, 15, 32'h0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0, 1,  32'h8C08_0004, 2,  32'h8C08_0004, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0500, 32'h5555_AAAA, 2, 32'h0, 3, 32'h0, 1'b1};

    rst_n = 1'b0; use_model = 1'b0; rdata_drv = '0; mem_ready = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #1;
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst timeout_err", timeout_err, 0);
    chk("rst acks", {i_ack, d_ack}, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    chk("idle ready ignored", {mem_req, i_ack, d_ack}, 0);
    mem_ready = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Collision: store wins, fetch follows after one idle cycle.
    mem_ready = 1'b1; rdata_drv = 32'h1111_2222;
    i_req = 1'b1; i_addr = 32'h0000_0080;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
    #1;
    chk("col stall_if c0", stall_if, 1);
    step();
    chk("col d_ack c1", d_ack, 1);
    chk("col i_ack c1", i_ack, 0);
    chk("col mem_we c1", mem_we, 1);
    chk("col mem_addr c1", mem_addr, 32'h100);
    chk("col mem_wdata c1", mem_wdata, 32'hDEAD_BEEF);
    chk("col stall_if c1", stall_if, 1);
    d_req = 1'b0;
    step();
    chk("col mem_req c2", mem_req, 0);
    chk("col acks c2", {i_ack, d_ack}, 0);
    chk("col stall_if c2", stall_if, 1);
    step();
    chk("col i_ack c3", i_ack, 1);
    chk("col d_ack c3", d_ack, 0);
    chk("col i_rdata c3", i_rdata, 32'h1111_2222);
    chk("col mem_we c3", mem_we, 0);
    chk("col mem_addr c3", mem_addr, 32'h80);
    i_req = 1'b0;
    step();
    mem_ready = 1'b0;

    // Back-to-back loads at zero wait.
    addrs[0] = 32'h600; addrs[1] = 32'h604; addrs[2] = 32'h608; addrs[3] = 32'h60C;
    use_model = 1'b1; mem_ready = 1'b1;
    k = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = addrs[0];
    for (int c = 1; c <= 10; c++) begin
      step();
      if (d_ack) begin
        a = addrs[k];
        chk($sformatf("b2b ack%0d cycle", k), c, 2 * k + 1);
        chk($sformatf("b2b ack%0d rdata", k), d_rdata, {~a[15:0], a[15:0]});
        k++;
        if (k < 4) d_addr = addrs[k];
        else       d_req = 1'b0;
      end
      if (k >= 4) break;
    end
    chk("b2b ack count", k, 4);
    d_req = 1'b0;
    step();
    use_model = 1'b0; mem_ready = 1'b0;

    // Reset during a waiting fetch.
    i_req = 1'b1; i_addr = 32'h900;
    step();
    chk("rmid mem_req c1", mem_req, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk("rmid mem_req async", mem_req, 0);
    chk("rmid i_ack", i_ack, 0);
    chk("rmid timeout_err", timeout_err, 0);
    chk("rmid mem_addr", mem_addr, 0);
    step();
    chk("rmid no ack held", {i_ack, d_ack, mem_req}, 0);
    i_req = 1'b0;
    rst_n = 1'b1;
    step();
    fv = '{1'b0, 1'b0, 32'h0000_0A00, 32'h0, 0, 32'h0123_4567, 1, 32'h0123_4567, 1'b0};
    run_vec(fv, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
